// File: rtl/conv_relu_pool_quant.sv
// ---------------------------------------------------------------------------
// conv_relu_pool_quant
//
// Post-processing stage behind the conv engine. It accepts raw signed
// accumulator results as a raster stream and, for each beat, applies ReLU and
// a rounding right shift that requantises to 7 magnitude bits. A 2x2 /
// stride-2 max-pool is then applied. Each pooled byte is written into SRAM
// with one byte lane enabled, four pooled pixels per word address.
// One start pulse processes one frame (one channel).
//
// Handshake: a beat is consumed on every cycle where in_valid is high while
// the block is in RUN. There is no back-pressure. Each wr_en cycle is a
// complete write: address, mask and data are valid together.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        one-cycle pulse that begins (or restarts) a frame
//   in_valid     in_data carries a beat this cycle
//   in_data      signed conv accumulator, raster (row-major) order
//   wr_en        SRAM write strobe, one cycle per pooled pixel
//   wr_addr      SRAM word address (pool index >> 2)
//   wr_bytemask  one-hot byte lane to write
//   wr_data      pooled byte replicated on all four lanes
//   busy         high while in RUN
//   done         one-cycle pulse after the last write of a frame
// ---------------------------------------------------------------------------
module conv_relu_pool_quant #(
   parameter int ACC_WIDTH   = 20,
   parameter int DATA_WIDTH  = 8,
   parameter int FMAP_W      = 24,
   parameter int FMAP_H      = 24,
   parameter int QUANT_SHIFT = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [ACC_WIDTH-1:0] in_data,
   output logic                 wr_en,
   output logic [9:0]           wr_addr,
   output logic [3:0]           wr_bytemask,
   output logic [31:0]          wr_data,
   output logic                 busy,
   output logic                 done
);

   localparam int C_W    = $clog2(FMAP_W);
   localparam int R_W    = $clog2(FMAP_H);
   localparam int HALF_W = FMAP_W / 2;

   // Rounding constant: half of one output LSB.
   localparam logic [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(2 ** (QUANT_SHIFT - 1));
   localparam logic [ACC_WIDTH:0] SAT = (ACC_WIDTH + 1)'(127);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [C_W-1:0]   c_q, c_d;
   logic [R_W-1:0]   r_q, r_d;
   logic [6:0]       hold_q, hold_d;
   logic [6:0]       lbuf_q [HALF_W];
   logic [6:0]       lbuf_d [HALF_W];
   logic             last_q, last_d;
   logic             wr_en_q, wr_en_d;
   logic [9:0]       wr_addr_q, wr_addr_d;
   logic [3:0]       wr_mask_q, wr_mask_d;
   logic [31:0]      wr_data_q, wr_data_d;

   // ---------------------------------------------------------------------
   // Per-beat datapath: ReLU, rounding shift, clip to 7 bits, pooling maxima
   // ---------------------------------------------------------------------
   logic [ACC_WIDTH-1:0] relu_v;
   logic [ACC_WIDTH:0]   rnd_sum;
   logic [ACC_WIDTH:0]   shifted;
   logic [6:0]           q;
   logic [6:0]           pair;
   logic [6:0]           lb_val;
   logic [6:0]           pooled;
   logic [C_W-2:0]       lb_idx;
   logic [11:0]          pool_idx;
   logic                 last_beat;

   always_comb begin
      relu_v  = in_data[ACC_WIDTH-1] ? '0 : in_data;
      // One extra bit so the rounding add can never wrap.
      rnd_sum = {1'b0, relu_v} + RND;
      shifted = rnd_sum >> QUANT_SHIFT;
      q       = (shifted > SAT) ? 7'd127 : shifted[6:0];

      pair    = (hold_q > q) ? hold_q : q;
      lb_idx  = c_q[C_W-1:1];
      lb_val  = lbuf_q[lb_idx];
      pooled  = (lb_val > pair) ? lb_val : pair;

      pool_idx  = 12'(r_q >> 1) * 12'(HALF_W) + 12'(c_q >> 1);
      last_beat = (c_q == C_W'(FMAP_W - 1)) && (r_q == R_W'(FMAP_H - 1));
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      r_d       = r_q;
      hold_d    = hold_q;
      lbuf_d    = lbuf_q;
      last_d    = last_q;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_mask_d = '0;
      wr_data_d = '0;

      if (start) begin
         // A start always wins: discard any partial frame, including a final
         // beat arriving in the same cycle. The line buffer needs no clear,
         // since every entry is rewritten on an even row before it is read.
         state_d = S_RUN;
         c_d     = '0;
         r_d     = '0;
         hold_d  = '0;
         last_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end

            S_RUN: begin
               if (last_q) begin
                  // Final write is on the bus this cycle; done follows.
                  state_d = S_DONE;
                  last_d  = 1'b0;
               end else if (in_valid) begin
                  if (!c_q[0]) begin
                     hold_d = q;
                  end else if (!r_q[0]) begin
                     lbuf_d[lb_idx] = pair;
                  end else begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = pool_idx[11:2];
                     wr_mask_d = 4'b0001 << pool_idx[1:0];
                     wr_data_d = {4{1'b0, pooled}};
                  end

                  last_d = last_beat;

                  if (c_q == C_W'(FMAP_W - 1)) begin
                     c_d = '0;
                     r_d = (r_q == R_W'(FMAP_H - 1)) ? '0 : r_q + 1'b1;
                  end else begin
                     c_d = c_q + 1'b1;
                  end
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         c_q       <= '0;
         r_q       <= '0;
         hold_q    <= '0;
         last_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_mask_q <= '0;
         wr_data_q <= '0;
         for (int i = 0; i < HALF_W; i++) begin
            lbuf_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         r_q       <= r_d;
         hold_q    <= hold_d;
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_mask_q <= wr_mask_d;
         wr_data_q <= wr_data_d;
         lbuf_q    <= lbuf_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_bytemask = wr_mask_q;
   assign wr_data     = wr_data_q;
   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_relu_pool_quant.sv
// ---------------------------------------------------------------------------
// tb_conv_relu_pool_quant
//
// Drives whole frames of conv results into conv_relu_pool_quant. Each frame
// pattern comes from a table of records. Every captured SRAM write is
// compared against a small pooling model plus hand-computed byte values.
// Hand-written sequences cover restart in RUN, start colliding with the
// final beat, and asynchronous reset mid-frame.
// ---------------------------------------------------------------------------
module tb_conv_relu_pool_quant;

   localparam int W     = 24;
   localparam int H     = 24;
   localparam int BEATS = W * H;
   localparam int NPOOL = (W / 2) * (H / 2);

   logic        clk;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [19:0] in_data;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [3:0]  wr_bytemask;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;

   conv_relu_pool_quant dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_bytemask (wr_bytemask),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- capture monitor (samples on the falling edge) ----------
   logic [9:0]  cap_addr [256];
   logic [3:0]  cap_mask [256];
   logic [31:0] cap_data [256];
   int          cap_n       = 0;
   int          done_n      = 0;
   int          cyc         = 0;
   int          last_wr_cyc = 0;
   int          done_cyc    = 0;
   logic        busy_at_done = 1'b1;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         if (cap_n < 256) begin
            cap_addr[cap_n] = wr_addr;
            cap_mask[cap_n] = wr_bytemask;
            cap_data[cap_n] = wr_data;
         end
         cap_n++;
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_n++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
   end

   // ---------------- reference model ----------------
   function automatic int beat_val(input int mode, input int val, input int r, input int c);
      if (mode == 0) return val;
      if (mode == 1) begin
         if (r == 0 && c == 0) return 0;
         if (r == 0 && c == 1) return 128;
         if (r == 1 && c == 0) return 256;
         if (r == 1 && c == 1) return 384;
         return 0;
      end
      return ((r * 37 + c * 53) * 7) % 3000 - 200;
   endfunction

   function automatic int quant(input int x);
      int y;
      if (x < 0) return 0;
      y = (x + 64) >>> 7;
      return (y > 127) ? 127 : y;
   endfunction

   function automatic int model_byte(input int mode, input int val, input int p);
      int pr, pc, m, v;
      pr = p / (W / 2);
      pc = p % (W / 2);
      m  = 0;
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++) begin
            v = quant(beat_val(mode, val, 2 * pr + dr, 2 * pc + dc));
            if (v > m) m = v;
         end
      return m;
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic clear_cap();
      cap_n        = 0;
      done_n       = 0;
      busy_at_done = 1'b1;
      for (int i = 0; i < 256; i++) begin
         cap_addr[i] = '0;
         cap_mask[i] = '0;
         cap_data[i] = '0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         start    = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Drives raster beats [first, last); leaves in_valid high after the last one.
   task automatic drive_range(input int mode, input int val, input bit gaps,
                              input int first, input int last);
      for (int i = first; i < last; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         @(negedge clk);
         start    = 1'b0;
         in_valid = 1'b1;
         in_data  = 20'(beat_val(mode, val, i / W, i % W));
      end
   endtask

   task automatic check_frame(input string name, input int mode, input int val,
                              input int byte0, input int byte143);
      logic [3:0] one;
      int         b;
      one = 4'b0001;
      chk({name, " write count"}, cap_n, NPOOL);
      for (int p = 0; p < NPOOL; p++) begin
         b = model_byte(mode, val, p);
         chk($sformatf("%s addr p=%0d", name, p), cap_addr[p], 32'(p >> 2));
         chk($sformatf("%s mask p=%0d", name, p), cap_mask[p], 32'(one << (p % 4)));
         chk($sformatf("%s data p=%0d", name, p), cap_data[p], {4{8'(b)}});
      end
      chk({name, " byte p=0"},   cap_data[0][7:0],   byte0);
      chk({name, " byte p=143"}, cap_data[143][7:0], byte143);
      chk({name, " done count"}, done_n, 1);
      chk({name, " done latency"}, done_cyc, last_wr_cyc + 1);
      chk({name, " busy at done"}, busy_at_done, 0);
   endtask

   // ---------------- frame vector table ----------------
   typedef struct {
      string name;
      int    mode;
      int    val;
      bit    gaps;
      int    exp_byte0;
      int    exp_byte143;
   } frame_vec_t;

   frame_vec_t vecs [6];

   initial begin
      // Hand-computed: (x + 64) >> 7, ReLU first, clip at 127.
      vecs[0] = '{"T1 const128",  0, 128,     1'b0, 1,   1};
      vecs[1] = '{"T2 relu",      0, -5000,   1'b0, 0,   0};
      vecs[2] = '{"T3 sat",       0, 524287,  1'b0, 127, 127};
      vecs[3] = '{"T4 window",    1, 0,       1'b0, 3,   0};
      vecs[4] = '{"const300 gap", 0, 300,     1'b1, 2,   2};
      vecs[5] = '{"ramp",         2, 0,       1'b0, 3,   18};

      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge clk);
      chk("reset wr_en", wr_en, 0);
      chk("reset wr_addr", wr_addr, 0);
      chk("reset wr_bytemask", wr_bytemask, 0);
      chk("reset wr_data", wr_data, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      rst = 1'b0;
      idle(2);

      // in_valid outside RUN is ignored.
      clear_cap();
      drive_range(0, 128, 1'b0, 0, 60);
      idle(3);
      chk("idle no writes", cap_n, 0);
      chk("idle busy", busy, 0);

      for (int v = 0; v < 6; v++) begin
         clear_cap();
         pulse_start();
         chk({vecs[v].name, " busy after start"}, busy, 1);
         drive_range(vecs[v].mode, vecs[v].val, vecs[v].gaps, 0, BEATS);
         idle(8);
         check_frame(vecs[v].name, vecs[v].mode, vecs[v].val,
                     vecs[v].exp_byte0, vecs[v].exp_byte143);
      end

      // T5: specific pool indices (from the last frame's capture).
      chk("T5 p=5 addr",   cap_addr[5],   1);
      chk("T5 p=5 mask",   cap_mask[5],   4'b0010);
      chk("T5 p=143 addr", cap_addr[143], 35);
      chk("T5 p=143 mask", cap_mask[143], 4'b1000);
      chk("T5 busy idle",  busy, 0);

      // Restart in RUN: partial frame discarded, new frame complete.
      pulse_start();
      drive_range(0, 1000, 1'b0, 0, 200);
      clear_cap();
      pulse_start();
      drive_range(2, 0, 1'b0, 0, BEATS);
      idle(8);
      check_frame("restart", 2, 0, 3, 18);

      // start coincides with the final beat: final write suppressed, no done.
      clear_cap();
      pulse_start();
      drive_range(0, 128, 1'b0, 0, BEATS - 1);
      @(negedge clk);
      in_valid = 1'b1;
      start    = 1'b1;
      in_data  = 20'(128);
      idle(6);
      chk("collide write count", cap_n, NPOOL - 1);
      chk("collide no done", done_n, 0);
      chk("collide still busy", busy, 1);
      clear_cap();
      drive_range(0, 524287, 1'b0, 0, BEATS);
      idle(8);
      check_frame("after collide", 0, 524287, 127, 127);

      // T6: gaps and async reset mid-frame, then a clean frame.
      clear_cap();
      pulse_start();
      drive_range(2, 0, 1'b1, 0, 150);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("T6 rst wr_en", wr_en, 0);
      chk("T6 rst wr_addr", wr_addr, 0);
      chk("T6 rst wr_bytemask", wr_bytemask, 0);
      chk("T6 rst wr_data", wr_data, 0);
      chk("T6 rst busy", busy, 0);
      chk("T6 rst done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      clear_cap();
      pulse_start();
      drive_range(2, 0, 1'b1, 0, BEATS);
      idle(8);
      check_frame("T6 clean", 2, 0, 3, 18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard bound so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
